seq_array_mul: RTL

- Parametrised, iterative successor to the team's 4x4 combinational array multiplier.
- Computes the WIDTH x WIDTH -> 2*WIDTH product with a radix-2 shift-add datapath, one partial-product row per clock.
- Trades latency for area; intended for datapaths where a full WIDTH^2 adder array is too large.
- Sits behind a start/done handshake. Operands are captured on start; the result is held until the next accepted start.

---
 rtl/seq_array_mul.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/seq_array_mul.sv
// -----------------------------------------------------------------------------
// seq_array_mul
//   Iterative WIDTH x WIDTH -> 2*WIDTH multiplier. It uses a radix-2 shift-add
//   datapath and retires one partial-product row per clock. It replaces the
//   fully combinational array multiplier where a WIDTH^2 adder array is too big.
//
//   Handshake (valid/ready style): start is a request that is accepted on a
//   rising edge only while busy=0. Operands a/b are captured on that edge.
//   busy stays high for exactly WIDTH cycles. done is a one-cycle pulse in the
//   first idle cycle, and from that cycle onward mul holds the product. mul is
//   held until the next operation completes or until reset. A start in the
//   same cycle as done is accepted, because the FSM is already idle.
//
//   Optional build macro: SEQ_ARRAY_MUL_SIGNED_EN
//     When undefined (default): unsigned operands and product.
//     When defined: two's complement operands and product. The datapath uses
//     a sign-extended accumulator. In the last row the multiplicand is
//     subtracted when the multiplier MSB is set.
//
//   Ports:
//     clk    in   rising-edge clock
//     rst    in   synchronous active-high reset (aborts any operation)
//     start  in   operation request
//     a      in   multiplicand [WIDTH-1:0]
//     b      in   multiplier   [WIDTH-1:0]
//     busy   out  operation in progress
//     done   out  single-cycle completion pulse
//     mul    out  product [2*WIDTH-1:0]
// -----------------------------------------------------------------------------
module seq_array_mul #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   mul
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t             state;
   state_t             state_nxt;

   logic [WIDTH-1:0]   mcand;
   // prod = {accumulator, multiplier}. The multiplier bits drain out of the
   // bottom while product bits fill in from the top.
   logic [2*WIDTH-1:0] prod;
   logic [CW-1:0]      cnt;

   logic               last;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod_nxt;

   assign last = (cnt == CW'(1));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy = (state == RUN);
   end

   // ---------------- one shift-add row ----------------
   // sum is one bit wider than the accumulator. In unsigned mode that bit is
   // the carry. In signed mode it is the sign of an exact (WIDTH+1)-bit
   // result. In both modes, shifting {sum, multiplier} right by one gives the
   // next state of prod. The bit that falls off the top of a plain shift is
   // exactly the carry or sign that the arithmetic already placed in sum[WIDTH].
`ifdef SEQ_ARRAY_MUL_SIGNED_EN
   logic [WIDTH:0] acc_x;
   logic [WIDTH:0] mcand_x;

   always_comb begin
      acc_x   = {prod[2*WIDTH-1], prod[2*WIDTH-1:WIDTH]};
      mcand_x = {mcand[WIDTH-1], mcand};
      sum     = acc_x;
      if (prod[0]) begin
         // The multiplier MSB carries weight -2^(WIDTH-1), so its row subtracts.
         if (last) sum = acc_x - mcand_x;
         else      sum = acc_x + mcand_x;
      end
   end
`else
   always_comb begin
      sum = {1'b0, prod[2*WIDTH-1:WIDTH]};
      if (prod[0]) sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
   end
`endif

   assign prod_nxt = {sum, prod[WIDTH-1:1]};

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand <= '0;
         prod  <= '0;
         cnt   <= '0;
         mul   <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mcand <= a;
                  prod  <= {{WIDTH{1'b0}}, b};
                  cnt   <= CW'(WIDTH);
               end
            end
            RUN: begin
               prod <= prod_nxt;
               cnt  <= cnt - CW'(1);
               if (last) begin
                  mul  <= prod_nxt;
                  done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
